accum_unit: RTL and testbench

ACCUM_UNIT -- requirements
Module: accum_unit

---
 rtl/accum_if.sv | 27 ++
 rtl/accum_unit.sv | 84 ++++++++
 tb/tb_accum_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/accum_if.sv
// Handshake bundle between accum_unit and its producer/consumer.
// Valid/ready: a beat or result moves on a rising edge where valid && ready are both high; the source holds its payload stable until then.
interface accum_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40
);
    logic                 start;
    logic [7:0]           len;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ready;
    logic                 busy;
    logic                 ovf;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/accum_unit.sv
// Run accumulator: sums len unsigned beats and offers the total once.
// Define ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module accum_unit #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40
) (
    input  logic       clk,
    input  logic       rst,
    accum_if.slave     bus,
    output logic [1:0] state_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam int         PAD     = ACC_WIDTH + 1 - WIDTH;

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;

    // One extra bit so the carry out doubles as the overflow detect.
    assign sum = {1'b0, acc_q} + {{PAD{1'b0}}, bus.in_data};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = bus.len;
                    state_d = (bus.len == 8'd0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    ovf_d   = ovf_q | sum[ACC_WIDTH];
`ifdef ACCUM_SATURATE_EN
                    acc_d   = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
                    acc_d   = sum[ACC_WIDTH-1:0];
`endif
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // start is deliberately ignored here, even alongside the handshake.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = (state_q == S_DONE) ? acc_q : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ovf       = ovf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_accum_unit.sv
// Bench for accum_unit: a 40-bit instance checked through a result scoreboard,
// plus a 33-bit instance for the overflow boundary (wrap or ACCUM_SATURATE_EN).
module tb_accum_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_a, state_b;

    accum_if #(.WIDTH(32), .ACC_WIDTH(40)) bus_a ();
    accum_if #(.WIDTH(32), .ACC_WIDTH(33)) bus_b ();

    accum_unit #(.WIDTH(32), .ACC_WIDTH(40)) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .state_o(state_a));
    accum_unit #(.WIDTH(32), .ACC_WIDTH(33)) dut_b (.clk(clk), .rst(rst), .bus(bus_b), .state_o(state_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [39:0] exp_q[$];
    logic        exp_ovf_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on each completed output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus_a.out_valid) begin
                check("zero_when_invalid", {24'd0, bus_a.out_data}, 64'd0);
            end else if (bus_a.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check("result_data", {24'd0, bus_a.out_data}, {24'd0, exp_q.pop_front()});
                    check("result_ovf", {63'd0, bus_a.ovf}, {63'd0, exp_ovf_q.pop_front()});
                end
            end
        end
    end

    task automatic start_run(input logic [7:0] l);
        bus_a.start = 1'b1;
        bus_a.len   = l;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_a.len   = $urandom_range(0, 255);
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = $urandom;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_beat_b(input logic [31:0] d);
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = d;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
    endtask

    initial begin
        logic [39:0] total;
        logic [31:0] d;
        int          l;

        bus_a.start = 0; bus_a.len = 0; bus_a.in_valid = 0; bus_a.in_data = 0; bus_a.out_ready = 1;
        bus_b.start = 0; bus_b.len = 0; bus_b.in_valid = 0; bus_b.in_data = 0; bus_b.out_ready = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus_a.in_ready, 0);
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_ovf", bus_a.ovf, 0);
        check("rst_state", state_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three back-to-back beats, valid one cycle after the last
        start_run(8'd3);
        check("run3_in_ready", bus_a.in_ready, 1);
        check("run3_busy", bus_a.busy, 1);
        exp_q.push_back(40'd60); exp_ovf_q.push_back(1'b0);
        send_beat(32'd10, 0);
        send_beat(32'd20, 0);
        send_beat(32'd30, 0);
        check("run3_latency", bus_a.out_valid, 1);
        check("run3_in_ready_done", bus_a.in_ready, 0);
        @(posedge clk); #1;
        check("run3_back_idle", state_a, 0);
        check("run3_drained", exp_q.size(), 0);

        // Empty run, result held while out_ready is low
        bus_a.out_ready = 1'b0;
        start_run(8'd0);
        check("len0_valid", bus_a.out_valid, 1);
        check("len0_in_ready", bus_a.in_ready, 0);
        check("len0_data", bus_a.out_data, 0);
        exp_q.push_back(40'd0); exp_ovf_q.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("len0_hold_valid", bus_a.out_valid, 1);
            check("len0_hold_data", bus_a.out_data, 0);
        end
        bus_a.out_ready = 1'b1;
        wait_drain();
        check("len0_idle", state_a, 0);

        // Gaps between beats, then a held nonzero result
        bus_a.out_ready = 1'b0;
        start_run(8'd2);
        send_beat(32'hFFFF_FFFF, 3);
        check("gap_still_accum", state_a, 1);
        check("gap_in_ready", bus_a.in_ready, 1);
        send_beat(32'hFFFF_FFFF, 0);
        exp_q.push_back(40'h1_FFFF_FFFE); exp_ovf_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("gap_hold_data", bus_a.out_data, 40'h1_FFFF_FFFE);
        end
        bus_a.out_ready = 1'b1;
        wait_drain();

        // start pulses during ACCUM and during the DONE handshake are ignored
        start_run(8'd2);
        bus_a.start = 1'b1; bus_a.len = 8'd5;
        send_beat(32'd7, 0);
        bus_a.start = 1'b0;
        exp_q.push_back(40'd12); exp_ovf_q.push_back(1'b0);
        send_beat(32'd5, 0);
        check("ign_done_after_2", bus_a.out_valid, 1);
        bus_a.start = 1'b1; bus_a.len = 8'd4;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check("ign_start_at_handshake", state_a, 0);
        check("ign_busy", bus_a.busy, 0);
        check("ign_drained", exp_q.size(), 0);

        // Reset mid-run discards the partial total
        start_run(8'd4);
        send_beat(32'd100, 0);
        send_beat(32'd200, 0);
        rst = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.start = 1'b1; bus_a.len = 8'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.start = 1'b0;
        check("mid_rst_state", state_a, 0);
        check("mid_rst_in_ready", bus_a.in_ready, 0);
        check("mid_rst_valid", bus_a.out_valid, 0);
        check("mid_rst_data", bus_a.out_data, 0);
        check("mid_rst_busy", bus_a.busy, 0);
        check("mid_rst_ovf", bus_a.ovf, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat($urandom, 0);
            check("mid_rst_no_valid", bus_a.out_valid, 0);
        end

        // Random runs with random gaps
        for (int r = 0; r < 6; r++) begin
            l = $urandom_range(1, 12);
            total = '0;
            start_run(l[7:0]);
            for (int b = 0; b < l; b++) begin
                d = $urandom;
                total = total + {8'd0, d};
                if (b == l - 1) begin
                    exp_q.push_back(total); exp_ovf_q.push_back(1'b0);
                end
                send_beat(d, $urandom_range(0, 2));
            end
            wait_drain();
        end

        // 33-bit accumulator overflow boundary
        bus_b.start = 1'b1; bus_b.len = 8'd3;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        send_beat_b(32'hFFFF_FFFF);
        send_beat_b(32'hFFFF_FFFF);
        check("ovf_not_yet", bus_b.ovf, 0);
        send_beat_b(32'hFFFF_FFFF);
        check("ovf_valid", bus_b.out_valid, 1);
        check("ovf_flag", bus_b.ovf, 1);
`ifdef ACCUM_SATURATE_EN
        check("ovf_data", bus_b.out_data, 33'h1_FFFF_FFFF);
`else
        check("ovf_data", bus_b.out_data, 33'h0_FFFF_FFFD);
`endif
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
        check("ovf_sticky_idle", bus_b.ovf, 1);
        bus_b.start = 1'b1; bus_b.len = 8'd1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        check("ovf_clear_on_start", bus_b.ovf, 0);
        send_beat_b(32'd9);
        check("ovf_b_small", bus_b.out_data, 33'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
